// File: rtl/sim_run_controller.sv
// Run-control for the RV32I core: sequences core reset, counts run cycles, and
// watches tohost writes for pass/fail. Timeout and, with RUN_STALL_DETECT_EN, stall detection.
module sim_run_controller #(
    parameter int                RESET_CYCLES   = 4,
    parameter int                TIMEOUT_CYCLES = 100,
    parameter int                CNT_W          = 32,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int                STALL_CYCLES   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              retire,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              done_pulse,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              stall
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_e;

    localparam int               HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                core_reset_q, core_reset_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [DATA_W-2:0]   fail_code_q, fail_code_d;
    logic                done_pulse_q, done_pulse_d;

    logic tohost_hit;
    logic timeout_hit;

    // Only odd values terminate; even values are console/char traffic.
    assign tohost_hit  = wr_en && (wr_addr == TOHOST_ADDR) && wr_data[0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count_q == TIMEOUT_LAST);

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        core_reset_d  = core_reset_q;
        cycle_count_d = cycle_count_q;
        fail_code_d   = fail_code_q;
        done_pulse_d  = 1'b0;

        if (restart) begin
            state_d       = S_HOLD;
            hold_cnt_d    = '0;
            core_reset_d  = 1'b1;
            cycle_count_d = '0;
            fail_code_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d      = S_RUN;
                        core_reset_d = 1'b0;
                        hold_cnt_d   = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;
                    // A terminating write beats a timeout landing on the same edge.
                    if (tohost_hit) begin
                        core_reset_d = 1'b1;
                        done_pulse_d = 1'b1;
                        if (wr_data == DATA_W'(1)) begin
                            state_d = S_PASS;
                        end else begin
                            state_d     = S_FAIL;
                            fail_code_d = wr_data[DATA_W-1:1];
                        end
                    end else if (timeout_hit) begin
                        state_d      = S_TIMEOUT;
                        core_reset_d = 1'b1;
                        done_pulse_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            core_reset_q  <= 1'b1;
            cycle_count_q <= '0;
            fail_code_q   <= '0;
            done_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            core_reset_q  <= core_reset_d;
            cycle_count_q <= cycle_count_d;
            fail_code_q   <= fail_code_d;
            done_pulse_q  <= done_pulse_d;
        end
    end

`ifdef RUN_STALL_DETECT_EN
    localparam int               IDLE_W   = $clog2(STALL_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALL_CYCLES);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              stall_q, stall_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        stall_d    = stall_q;
        if (restart) begin
            idle_cnt_d = '0;
            stall_d    = 1'b0;
        end else if (state_q == S_RUN) begin
            if (retire) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (idle_cnt_d == IDLE_MAX) stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign stall         = 1'b0;
`endif

    // Status is a decode of registered state only, so no input reaches an output combinationally.
    assign core_reset  = core_reset_q;
    assign running     = (state_q == S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = pass || fail || timeout;
    assign done_pulse  = done_pulse_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Scoreboard bench for sim_run_controller: directed runs push the expected terminal
// status; a monitor compares it whenever done_pulse fires.
module tb_sim_run_controller;

    logic        clk;
    logic        reset;
    logic        restart;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        retire;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        done_pulse;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic        stall;

`ifdef RUN_STALL_DETECT_EN
    localparam logic EXP_STALL = 1'b1;
`else
    localparam logic EXP_STALL = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic [30:0] code;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    sim_run_controller dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .retire     (retire),
        .core_reset (core_reset),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse),
        .pass       (pass),
        .fail       (fail),
        .timeout    (timeout),
        .fail_code  (fail_code),
        .cycle_count(cycle_count),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every terminal entry must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && done_pulse) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_pass"},       pass,        e.pass);
                check({e.name, "_fail"},       fail,        e.fail);
                check({e.name, "_timeout"},    timeout,     e.timeout);
                check({e.name, "_fail_code"},  fail_code,   e.code);
                check({e.name, "_cycle_count"}, cycle_count, e.count);
                check({e.name, "_core_reset"}, core_reset,  1'b1);
                check({e.name, "_done"},       done,        1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input string name, input logic p, input logic f, input logic t,
                               input logic [30:0] code, input logic [31:0] count);
        exp_t e;
        e.name = name; e.pass = p; e.fail = f; e.timeout = t; e.code = code; e.count = count;
        exp_q.push_back(e);
    endtask

    // Four edges of core reset, RUN entered on the fourth with the counter at zero.
    task automatic hold_seq(input string name);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check({name, "_hold_core_reset"}, core_reset, (i < 4));
            check({name, "_hold_running"},    running,    (i == 4));
        end
        check({name, "_run_start_count"}, cycle_count, 0);
    endtask

    task automatic wait_count(input logic [31:0] target, input int budget);
        for (int i = 0; i < budget && cycle_count != target; i++) tick();
        check("reach_cycle_count", cycle_count, target);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_within_budget", done, 1'b1);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_restart(input string name);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check({name, "_core_reset"}, core_reset, 1'b1);
        check({name, "_status"}, {running, done, pass, fail, timeout, stall}, 6'b0);
        check({name, "_count"},  cycle_count, 0);
        check({name, "_code"},   fail_code, 0);
    endtask

    initial begin
        reset = 1'b0; restart = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; retire = 1'b0;
        repeat (3) tick();
        check("reset_core_reset", core_reset, 1'b1);
        check("reset_status", {running, done, done_pulse, pass, fail, timeout, stall}, 7'b0);
        check("reset_count", cycle_count, 0);
        check("reset_code", fail_code, 0);

        // Run 1: power-up hold, then PASS at cycle 20.
        reset = 1'b1;
        hold_seq("run1");
        tick();
        check("run1_count_inc", cycle_count, 1);
        wait_count(20, 40);
        expect_done("run1_pass", 1, 0, 0, 0, 21);
        bus_write(32'h1000, 32'h1);
        wait_done(4);
        tick();
        check("run1_pulse_one_cycle", done_pulse, 1'b0);
        check("run1_pass_sticky", pass, 1'b1);
        check("run1_count_frozen", cycle_count, 21);

        // Run 2: ignored writes, then FAIL with code 3; terminal writes ignored.
        do_restart("restart2");
        hold_seq("run2");
        wait_count(5, 20);
        bus_write(32'h1000, 32'h0);
        bus_write(32'h1004, 32'h1);
        check("run2_ignored_writes", {running, done}, 2'b10);
        wait_count(10, 20);
        expect_done("run2_fail", 0, 1, 0, 3, 11);
        bus_write(32'h1000, 32'h7);
        wait_done(4);
        bus_write(32'h1000, 32'h0);
        bus_write(32'h1000, 32'h1);
        check("run2_fail_sticky", {pass, fail, timeout}, 3'b010);
        check("run2_code_held", fail_code, 3);
        check("run2_count_frozen", cycle_count, 11);

        // Run 3: hit on the timeout cycle wins.
        do_restart("restart3");
        hold_seq("run3");
        wait_count(99, 150);
        expect_done("run3_race_pass", 1, 0, 0, 0, 100);
        bus_write(32'h1000, 32'h1);
        wait_done(4);
        check("run3_no_timeout", timeout, 1'b0);

        // Run 4: retire pattern, then idle stretch, then TIMEOUT.
        do_restart("restart4");
        hold_seq("run4");
        expect_done("run4_timeout", 0, 0, 1, 0, 100);
        for (int g = 0; g < 5; g++) begin
            retire = 1'b1;
            tick();
            retire = 1'b0;
            repeat (9) tick();
        end
        check("run4_stall_with_retires", stall, 1'b0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        repeat (15) tick();
        check("run4_stall_15_idle", stall, 1'b0);
        tick();
        check("run4_stall_16_idle", stall, EXP_STALL);
        wait_done(100);
        tick();
        check("run4_timeout_sticky", {timeout, done_pulse}, 2'b10);
        check("run4_count_frozen", cycle_count, 100);
        check("run4_stall_kept", stall, EXP_STALL);

        // Run 5: asynchronous reset mid-RUN.
        do_restart("restart5");
        hold_seq("run5");
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        check("async_reset_core_reset", core_reset, 1'b1);
        check("async_reset_status", {running, done, done_pulse, pass, fail, timeout, stall}, 7'b0);
        check("async_reset_count", cycle_count, 0);
        tick();
        reset = 1'b1;
        hold_seq("run6");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench did not terminate");
    end

endmodule
